// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM states and requester ids for the data-memory port arbiter
package dmem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: sub-word store lane placement, load extraction/extension and access legality check
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  logic [31:0] sh;
  logic illegal, misal;
  always_comb begin
    sh = rdata_i >> {addr_lo_i, 3'b000};
    be_o = funct3_i[1] ? 4'b1111 : (funct3_i[0] ? 4'b0011 : 4'b0001) << addr_lo_i;
    wdata_o = wdata_i << {addr_lo_i, 3'b000};
    illegal = funct3_i == 3'b011 || funct3_i[2:1] == 2'b11 || (we_i && funct3_i[2]);
    misal = (funct3_i[1:0] == 2'b01 && addr_lo_i[0]) || (funct3_i[1:0] == 2'b10 && addr_lo_i != 2'b00);
    err_o = illegal || misal;
    rdata_o = funct3_i == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
              funct3_i == F3_LBU ? {24'h0, sh[7:0]} :
              funct3_i == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
              funct3_i == F3_LHU ? {16'h0, sh[15:0]} :
              funct3_i == F3_LW  ? sh : 32'h0;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin fetch/LSU arbiter sequencing one access at a time through a fixed-latency memory
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, we_q;
  logic [2:0] f3_q;
  logic [1:0] lo_q;
  logic if_rvalid_q, ls_rvalid_q, ls_err_q;
  logic [31:0] if_rdata_q, ls_rdata_q;
  logic in_wait, done, can_gnt, pick_ls, any_gnt, a_err;
  logic [3:0] a_be;
  logic [31:0] a_wdata, a_rdata;
  logic unused_addr_bits;
  assign in_wait = state_q == S_WAIT;
  assign done = in_wait && cnt_q == CW'(1);
  assign can_gnt = rst_n && !in_wait;
  assign pick_ls = ls_req && (!if_req || last_q == REQ_IF);
  assign ls_gnt = can_gnt && pick_ls;
  assign if_gnt = can_gnt && if_req && !pick_ls;
  assign any_gnt = ls_gnt || if_gnt;
  assign unused_addr_bits = ^if_addr[1:0];
  assign if_rvalid = if_rvalid_q;
  assign if_rdata = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata = ls_rdata_q;
  assign ls_err = ls_err_q;
  // grant path sees the live LS request, response path the attributes latched at grant
  dmem_lane_align u_align (
    .funct3_i (in_wait ? f3_q : ls_funct3),
    .we_i     (in_wait ? we_q : ls_we),
    .addr_lo_i(in_wait ? lo_q : ls_addr[1:0]),
    .wdata_i  (ls_wdata),
    .rdata_i  (mem_rdata),
    .be_o     (a_be),
    .wdata_o  (a_wdata),
    .rdata_o  (a_rdata),
    .err_o    (a_err)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      last_q <= REQ_IF;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (any_gnt) last_q <= ls_gnt ? REQ_LS : REQ_IF;
    end
  end
  always_comb begin
    state_d = any_gnt ? (ls_gnt && a_err ? S_RESP : S_WAIT) : S_IDLE;
    cnt_d = any_gnt ? CW'(MEM_LAT) : cnt_q;
    if (in_wait) begin
      state_d = done ? S_RESP : S_WAIT;
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_comb begin
    mem_en = if_gnt || (ls_gnt && !a_err);
    mem_we = ls_gnt && !a_err && ls_we;
    mem_be = mem_we ? a_be : 4'b0000;
    mem_wdata = mem_we ? a_wdata : 32'h0;
    mem_addr = if_gnt ? if_addr[ADDR_W-1:2] : mem_en ? ls_addr[ADDR_W-1:2] : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      lo_q <= '0;
    end else begin
      if_rvalid_q <= done && last_q == REQ_IF;
      ls_rvalid_q <= (done && last_q == REQ_LS) || (ls_gnt && a_err);
      ls_err_q <= ls_gnt && a_err;
      if (ls_gnt) begin
        f3_q <= ls_funct3;
        we_q <= ls_we;
        lo_q <= ls_addr[1:0];
      end
      if (done && last_q == REQ_IF) if_rdata_q <= mem_rdata;
      if (done && last_q == REQ_LS) ls_rdata_q <= we_q ? 32'h0 : a_rdata;
      if (ls_gnt && a_err) ls_rdata_q <= 32'h0;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vector bench for the arbiter at memory latency 1 and 3
module tb_dmem_port_arbiter;
  logic clk, rst_n;
  logic a_if_req, a_if_gnt, a_if_rvalid, a_ls_req, a_ls_we, a_ls_gnt, a_ls_rvalid, a_ls_err, a_mem_en, a_mem_we;
  logic [31:0] a_if_addr, a_ls_addr, a_if_rdata, a_ls_wdata, a_ls_rdata, a_mem_wdata, a_mem_rdata;
  logic [2:0] a_ls_f3;
  logic [3:0] a_mem_be;
  logic [29:0] a_mem_addr;
  logic b_if_req, b_if_gnt, b_if_rvalid, b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid, b_ls_err, b_mem_en, b_mem_we;
  logic [31:0] b_if_addr, b_ls_addr, b_if_rdata, b_ls_wdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
  logic [2:0] b_ls_f3;
  logic [3:0] b_mem_be;
  logic [29:0] b_mem_addr;
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] b_p0, b_p1;
  int tests, fails;

  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
    logic en; logic [3:0] be; logic [31:0] mwdata; logic err; logic [31:0] rdata;
  } vec_t;
  vec_t tv [0:14];
  logic [3:0] rr_exp [0:8];

  dmem_port_arbiter #(.ADDR_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata), .ls_req(a_ls_req), .ls_we(a_ls_we),
    .ls_funct3(a_ls_f3), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata), .ls_gnt(a_ls_gnt),
    .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata), .ls_err(a_ls_err), .mem_en(a_mem_en),
    .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata));

  dmem_port_arbiter #(.ADDR_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata), .ls_req(b_ls_req), .ls_we(b_ls_we),
    .ls_funct3(b_ls_f3), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata), .ls_gnt(b_ls_gnt),
    .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata), .ls_err(b_ls_err), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (a_mem_be[k]) mem1[a_mem_addr[5:0]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      end else a_mem_rdata <= mem1[a_mem_addr[5:0]];
    end
  end

  always @(posedge clk) begin
    b_p0 <= (b_mem_en && !b_mem_we) ? mem3[b_mem_addr[5:0]] : 32'h0;
    b_p1 <= b_p0;
    b_mem_rdata <= b_p1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_ls(input int i);
    int n;
    vec_t v;
    v = tv[i];
    @(negedge clk);
    a_ls_req = 1'b1; a_ls_we = v.we; a_ls_f3 = v.f3; a_ls_addr = v.addr; a_ls_wdata = v.wdata;
    #1;
    n = 0;
    while (!a_ls_gnt && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("v%0d_gnt", i), {31'h0, a_ls_gnt}, 32'h1);
    if (!a_ls_gnt) begin
      a_ls_req = 1'b0;
      return;
    end
    chk($sformatf("v%0d_ctl", i), {26'h0, a_mem_en, a_mem_we, a_mem_be}, {26'h0, v.en, v.en & v.we, v.be});
    chk($sformatf("v%0d_addr", i), {2'b0, a_mem_addr}, v.en ? {2'b0, v.addr[31:2]} : 32'h0);
    chk($sformatf("v%0d_wdata", i), a_mem_wdata, v.mwdata);
    @(posedge clk); #1;
    a_ls_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!a_ls_rvalid && n < 10);
    chk($sformatf("v%0d_lat", i), n, v.err ? 1 : 2);
    chk($sformatf("v%0d_err", i), {31'h0, a_ls_err}, {31'h0, v.err});
    chk($sformatf("v%0d_rdata", i), a_ls_rdata, v.rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int if_rv_at, ls_g_at, ls_rv_at, seen;
    tests = 0; fails = 0;
    for (int k = 0; k < 64; k++) begin mem1[k] = 32'h0; mem3[k] = 32'h0; end
    mem1[20] = 32'hCAFEF00D;
    mem3[16] = 32'h11223344;
    mem3[17] = 32'h55667788;
    a_mem_rdata = 32'h0; b_mem_rdata = 32'h0; b_p0 = 32'h0; b_p1 = 32'h0;
    tv[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'hFFFFDEAD};
    tv[2]  = '{1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0000DEAD};
    tv[3]  = '{1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'hFFFFFFDE};
    tv[4]  = '{1'b1, 3'b000, 32'h21, 32'h5A, 1'b1, 4'h2, 32'h00005A00, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 3'b100, 32'h21, 32'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0000005A};
    tv[6]  = '{1'b1, 3'b001, 32'h22, 32'h1234, 1'b1, 4'hC, 32'h12340000, 1'b0, 32'h0};
    tv[7]  = '{1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h12345A00};
    tv[8]  = '{1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'hFFFFFFEF};
    tv[9]  = '{1'b0, 3'b010, 32'h06, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0};
    tv[10] = '{1'b0, 3'b011, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0};
    tv[11] = '{1'b0, 3'b001, 32'h11, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0};
    tv[12] = '{1'b1, 3'b010, 32'h12, 32'hFFFF, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0};
    tv[13] = '{1'b1, 3'b100, 32'h10, 32'hFF, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0};
    tv[14] = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    rr_exp = '{4'b0100, 4'b0000, 4'b1001, 4'b0000, 4'b0110, 4'b0000, 4'b1001, 4'b0000, 4'b0010};
    a_if_req = 0; a_if_addr = 0; a_ls_req = 0; a_ls_we = 0; a_ls_f3 = 0; a_ls_addr = 0; a_ls_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_ls_req = 0; b_ls_we = 0; b_ls_f3 = 0; b_ls_addr = 0; b_ls_wdata = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ctl", {21'h0, a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_ls_err, a_mem_en, a_mem_we, a_mem_be}, 32'h0);
    chk("rst_a_data", a_if_rdata | a_ls_rdata | a_mem_wdata | {2'b0, a_mem_addr}, 32'h0);
    chk("rst_b_ctl", {21'h0, b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_ls_err, b_mem_en, b_mem_we, b_mem_be}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_ls(i);

    // round robin from reset: LS first, then alternating, responses two cycles apart
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    a_if_req = 1'b1; a_if_addr = 32'h50;
    a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_f3 = 3'b010; a_ls_addr = 32'h10;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 7) begin a_if_req = 1'b0; a_ls_req = 1'b0; end
      #1;
      chk($sformatf("rr_c%0d", c), {28'h0, a_if_gnt, a_ls_gnt, a_if_rvalid, a_ls_rvalid}, {28'h0, rr_exp[c]});
      if (c == 2) begin
        chk("rr_ls_rdata", a_ls_rdata, 32'hDEADBEEF);
        chk("rr_if_mem", {1'b0, a_mem_we, a_mem_addr}, 32'h14);
      end
      if (c == 4) chk("rr_if_rdata", a_if_rdata, 32'hCAFEF00D);
    end

    // latency 3: fetch, then an LS request raised one cycle later waits for the response cycle
    @(negedge clk);
    b_if_req = 1'b1; b_if_addr = 32'h40;
    #1;
    chk("l3_if_gnt", {29'h0, b_if_gnt, b_mem_en, b_mem_we}, 32'h6);
    chk("l3_if_addr", {2'b0, b_mem_addr}, 32'h10);
    @(posedge clk); #1;
    b_if_req = 1'b0;
    if_rv_at = -1; ls_g_at = -1; ls_rv_at = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_f3 = 3'b010; b_ls_addr = 32'h44; end
      if (ls_g_at >= 0) b_ls_req = 1'b0;
      #1;
      if (b_if_rvalid && if_rv_at < 0) begin if_rv_at = c; chk("l3_if_rdata", b_if_rdata, 32'h11223344); end
      if (b_ls_gnt && ls_g_at < 0) ls_g_at = c;
      if (b_ls_rvalid && ls_rv_at < 0) begin ls_rv_at = c; chk("l3_ls_rdata", b_ls_rdata, 32'h55667788); end
    end
    chk("l3_if_rv_at", if_rv_at, 4);
    chk("l3_ls_gnt_at", ls_g_at, 4);
    chk("l3_ls_rv_at", ls_rv_at, 8);

    // reset during WAIT drops the response
    @(negedge clk);
    b_if_req = 1'b1; b_if_addr = 32'h40;
    #1;
    chk("rw_gnt", {31'h0, b_if_gnt}, 32'h1);
    @(posedge clk); #1;
    b_if_req = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rw_ctl", {21'h0, b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_ls_err, b_mem_en, b_mem_we, b_mem_be}, 32'h0);
    chk("rw_data", b_if_rdata | b_ls_rdata | b_mem_wdata | {2'b0, b_mem_addr}, 32'h0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b_if_rvalid || b_ls_rvalid) seen++;
    end
    chk("rw_no_rvalid", seen, 0);
    b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_f3 = 3'b010; b_ls_addr = 32'h44;
    #1;
    chk("rw_ls_gnt", {31'h0, b_ls_gnt}, 32'h1);
    @(posedge clk); #1;
    b_ls_req = 1'b0;
    seen = 0;
    while (!b_ls_rvalid && seen < 10) begin @(negedge clk); seen++; end
    chk("rw_ls_lat", seen, 4);
    chk("rw_ls_rdata", b_ls_rdata, 32'h55667788);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
